// File: rtl/lane_align_ctrl_pkg.sv
// Shared types and default parameters for the lane alignment controller.
package lane_align_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        SLIP,
        NEXT,
        DONE
    } align_state_t;

    localparam int   DEF_LANES         = 8;
    localparam int   DEF_SETTLE_CYCLES = 4;
    localparam int   DEF_CHECK_CYCLES  = 16;
    localparam int   DEF_MAX_TRIES     = 3;
    localparam logic DEF_TRAIN_RISE    = 1'b1;

    // Index width that never collapses to zero bits for a single lane.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lane_align_ctrl_if.sv
// Bus between the alignment controller, the slip datapath and the bring-up sequencer.
interface lane_align_ctrl_if
    import lane_align_pkg::*;
#(
    parameter int LANES = DEF_LANES
);
    logic             start;
    logic             abort;
    logic [LANES-1:0] lane_rise;
    logic [LANES-1:0] lane_fall;
    logic [LANES-1:0] bitslip_pulse;
    logic             busy;
    logic             done;
    logic [LANES-1:0] locked;
    logic [LANES-1:0] fail;

    modport master (
        output start, abort, lane_rise, lane_fall,
        input  bitslip_pulse, busy, done, locked, fail
    );

    modport slave (
        input  start, abort, lane_rise, lane_fall,
        output bitslip_pulse, busy, done, locked, fail
    );
endinterface

// File: rtl/lane_pattern_checker.sv
// Counts training-pattern and inverted-pattern hits on the selected lane over one window.
module lane_pattern_checker
    import lane_align_pkg::*;
#(
    parameter int   CHECK_CYCLES = DEF_CHECK_CYCLES,
    parameter logic TRAIN_RISE   = DEF_TRAIN_RISE,
    localparam int  CW           = $clog2(CHECK_CYCLES + 1)
) (
    input  logic          dco_clk,
    input  logic          rst,
    input  logic          rise,
    input  logic          fall,
    input  logic          clear,
    input  logic          sample,
    output logic [CW-1:0] match_cnt,
    output logic [CW-1:0] inv_cnt,
    output logic          all_match,
    output logic          all_inv
);
    localparam logic [CW-1:0] FULL = CW'(CHECK_CYCLES);

    logic          hit_match, hit_inv;
    logic [CW-1:0] match_nxt, inv_nxt;

    // Flags fold in the current sample so the last window cycle sees a complete count.
    always_comb begin
        hit_match = sample && (rise == TRAIN_RISE)  && (fall == ~TRAIN_RISE) && (match_cnt != FULL);
        hit_inv   = sample && (rise == ~TRAIN_RISE) && (fall == TRAIN_RISE)  && (inv_cnt != FULL);
        match_nxt = match_cnt + CW'(hit_match);
        inv_nxt   = inv_cnt + CW'(hit_inv);
        all_match = (match_nxt == FULL);
        all_inv   = (inv_nxt == FULL);
    end

    always_ff @(posedge dco_clk) begin
        if (rst || clear) begin
            match_cnt <= '0;
            inv_cnt   <= '0;
        end else begin
            match_cnt <= match_nxt;
            inv_cnt   <= inv_nxt;
        end
    end
endmodule

// File: rtl/lane_align_ctrl.sv
// Training-time alignment controller: walks the lanes, checks the pattern, requests slips.
module lane_align_ctrl
    import lane_align_pkg::*;
#(
    parameter int   LANES         = DEF_LANES,
    parameter int   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int   CHECK_CYCLES  = DEF_CHECK_CYCLES,
    parameter int   MAX_TRIES     = DEF_MAX_TRIES,
    parameter logic TRAIN_RISE    = DEF_TRAIN_RISE
) (
    input  logic              dco_clk,
    input  logic              rst,
    lane_align_ctrl_if.slave  bus
);
    localparam int IW = idx_width(LANES);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int CW = $clog2(CHECK_CYCLES + 1);

    align_state_t     state, state_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [TW-1:0]    tries, tries_nxt;
    logic [SW-1:0]    settle_cnt, settle_nxt;
    logic [CW-1:0]    check_cnt, check_nxt;
    logic [LANES-1:0] locked_q, locked_nxt;
    logic [LANES-1:0] fail_q, fail_nxt;
    logic [LANES-1:0] pulse_q, pulse_nxt;
    logic             busy_q, done_q;

    logic             lane_r, lane_f;
    logic             all_match, all_inv;
    logic [CW-1:0]    match_cnt, inv_cnt;
    logic             unused_cnt_bits;

    assign lane_r = bus.lane_rise[idx];
    assign lane_f = bus.lane_fall[idx];

    lane_pattern_checker #(
        .CHECK_CYCLES (CHECK_CYCLES),
        .TRAIN_RISE   (TRAIN_RISE)
    ) u_checker (
        .dco_clk   (dco_clk),
        .rst       (rst),
        .rise      (lane_r),
        .fall      (lane_f),
        .clear     (state == SETTLE),
        .sample    (state == CHECK),
        .match_cnt (match_cnt),
        .inv_cnt   (inv_cnt),
        .all_match (all_match),
        .all_inv   (all_inv)
    );

    // Only the flags steer the FSM; the raw counts are for observation.
    assign unused_cnt_bits = ^{match_cnt, inv_cnt};

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        tries_nxt  = tries;
        settle_nxt = settle_cnt;
        check_nxt  = check_cnt;
        locked_nxt = locked_q;
        fail_nxt   = fail_q;

        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    locked_nxt = '0;
                    fail_nxt   = '0;
                    idx_nxt    = '0;
                    tries_nxt  = '0;
                    settle_nxt = '0;
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    settle_nxt = '0;
                    check_nxt  = '0;
                    state_nxt  = CHECK;
                end else begin
                    settle_nxt = settle_cnt + SW'(1);
                end
            end
            CHECK: begin
                if (check_cnt == CW'(CHECK_CYCLES - 1)) begin
                    check_nxt = '0;
                    if (all_match) begin
                        locked_nxt[idx] = 1'b1;
                        state_nxt       = NEXT;
                    end else if (tries == TW'(MAX_TRIES - 1)) begin
                        fail_nxt[idx] = 1'b1;
                        state_nxt     = NEXT;
                    end else if (all_inv) begin
                        state_nxt = SLIP;
                    end else begin
                        tries_nxt = tries + TW'(1);
                        state_nxt = SETTLE;
                    end
                end else begin
                    check_nxt = check_cnt + CW'(1);
                end
            end
            SLIP: begin
                tries_nxt = tries + TW'(1);
                state_nxt = SETTLE;
            end
            NEXT: begin
                if (idx == IW'(LANES - 1)) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + IW'(1);
                    tries_nxt = '0;
                    state_nxt = SETTLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Abort drops the in-flight decision but keeps status earned on earlier lanes.
        if (bus.abort && state != IDLE) begin
            state_nxt  = IDLE;
            locked_nxt = locked_q;
            fail_nxt   = fail_q;
            settle_nxt = '0;
            check_nxt  = '0;
        end

        pulse_nxt = '0;
        if (state_nxt == SLIP)
            pulse_nxt = LANES'(1) << idx_nxt;
    end

    always_ff @(posedge dco_clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            tries      <= '0;
            settle_cnt <= '0;
            check_cnt  <= '0;
            locked_q   <= '0;
            fail_q     <= '0;
            pulse_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            tries      <= tries_nxt;
            settle_cnt <= settle_nxt;
            check_cnt  <= check_nxt;
            locked_q   <= locked_nxt;
            fail_q     <= fail_nxt;
            pulse_q    <= pulse_nxt;
            busy_q     <= (state_nxt != IDLE);
            done_q     <= (state_nxt == DONE);
        end
    end

    assign bus.bitslip_pulse = pulse_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.locked        = locked_q;
    assign bus.fail          = fail_q;
endmodule

// File: tb/tb_lane_align_ctrl.sv
// Directed scenarios for lane_align_ctrl with a small slip-stage lane model.
module tb_lane_align_ctrl;
    logic dco_clk = 1'b0;
    logic rst     = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    lane_align_ctrl_if #(.LANES(8)) bus ();

    lane_align_ctrl #(
        .LANES         (8),
        .SETTLE_CYCLES (4),
        .CHECK_CYCLES  (16),
        .MAX_TRIES     (3),
        .TRAIN_RISE    (1'b1)
    ) dut (
        .dco_clk (dco_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 dco_clk = ~dco_clk;

    // Lane behaviour: 0 clean, 1 inverted until slipped, 2 noise, 3 inverted and slip ignored.
    int         mode  [8] = '{default: 0};
    int         pbase [8] = '{default: 0};
    int         pcnt  [8] = '{default: 0};
    int         bad_pulse = 0;
    int         done_seen = 0;
    int         nz_ctr    = 0;
    logic [7:0] last_pulse = '0;
    logic       nz_r = 1'b1, nz_f = 1'b1;
    logic [7:0] lr, lf;

    always_comb begin
        lr = '0;
        lf = '0;
        for (int i = 0; i < 8; i++) begin
            case (mode[i])
                1: begin
                    lr[i] = (pcnt[i] > pbase[i]);
                    lf[i] = !(pcnt[i] > pbase[i]);
                end
                2: begin lr[i] = nz_r; lf[i] = nz_f; end
                3: begin lr[i] = 1'b0; lf[i] = 1'b1; end
                default: begin lr[i] = 1'b1; lf[i] = 1'b0; end
            endcase
        end
    end
    assign bus.lane_rise = lr;
    assign bus.lane_fall = lf;

    always @(negedge dco_clk) begin
        if (bus.bitslip_pulse != 8'h00) begin
            last_pulse <= bus.bitslip_pulse;
            if (!$onehot(bus.bitslip_pulse)) bad_pulse <= bad_pulse + 1;
            for (int i = 0; i < 8; i++)
                if (bus.bitslip_pulse[i]) pcnt[i] <= pcnt[i] + 1;
        end
        if (bus.done) done_seen <= done_seen + 1;
        nz_ctr <= nz_ctr + 1;
        // Every fifth sample is (1,1), so no 16-cycle noise window can look uniform.
        if (nz_ctr % 5 == 0) begin
            nz_r <= 1'b1; nz_f <= 1'b1;
        end else begin
            nz_r <= 1'($urandom); nz_f <= 1'($urandom);
        end
    end

    task automatic step();
        @(posedge dco_clk); #1;
    endtask

    function automatic int pulse_delta();
        int s = 0;
        for (int i = 0; i < 8; i++) s += pcnt[i] - pbase[i];
        return s;
    endfunction

    task automatic set_modes(input int m0, input int m2, input int m3, input int m5);
        for (int i = 0; i < 8; i++) mode[i] = 0;
        mode[0] = m0; mode[2] = m2; mode[3] = m3; mode[5] = m5;
        pbase = pcnt;
    endtask

    // Pulses start; returns the cycle (1 = first cycle after the start edge) in which done is seen.
    task automatic run_to_done(output int cyc);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 400) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
        step(); step();
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'h00) $display("FAIL reset_locked got %h want 00", bus.locked); else pass_cnt++;
        total_cnt++; if (bus.fail !== 8'h00) $display("FAIL reset_fail got %h want 00", bus.fail); else pass_cnt++;
        total_cnt++; if (bus.bitslip_pulse !== 8'h00) $display("FAIL reset_pulse got %h want 00", bus.bitslip_pulse); else pass_cnt++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_all_clean();
        int cyc;
        set_modes(0, 0, 0, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL clean_busy_rise got %b want 1", bus.busy); else pass_cnt++;
        // A start pulse mid-training must neither restart nor clear status.
        while (bus.done !== 1'b1 && cyc < 400) begin
            bus.start = (cyc == 100);
            step();
            cyc++;
        end
        bus.start = 1'b0;
        total_cnt++; if (cyc != 169) $display("FAIL clean_done_cycle got %0d want 169", cyc); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'hFF) $display("FAIL clean_locked got %h want ff", bus.locked); else pass_cnt++;
        total_cnt++; if (bus.fail !== 8'h00) $display("FAIL clean_fail got %h want 00", bus.fail); else pass_cnt++;
        total_cnt++; if (pulse_delta() != 0) $display("FAIL clean_pulses got %0d want 0", pulse_delta()); else pass_cnt++;
        step();
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL clean_done_width got %b want 0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL clean_busy_fall got %b want 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_slip_lane3();
        int cyc;
        set_modes(0, 0, 1, 0);
        step();
        run_to_done(cyc);
        total_cnt++; if (cyc != 190) $display("FAIL slip3_done_cycle got %0d want 190", cyc); else pass_cnt++;
        total_cnt++; if (pulse_delta() != 1) $display("FAIL slip3_pulse_count got %0d want 1", pulse_delta()); else pass_cnt++;
        total_cnt++; if (last_pulse !== 8'h08) $display("FAIL slip3_pulse_value got %h want 08", last_pulse); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'hFF) $display("FAIL slip3_locked got %h want ff", bus.locked); else pass_cnt++;
        total_cnt++; if (bus.fail !== 8'h00) $display("FAIL slip3_fail got %h want 00", bus.fail); else pass_cnt++;
    endtask

    task automatic test_noise_lane5();
        int cyc;
        set_modes(0, 0, 0, 2);
        step();
        run_to_done(cyc);
        total_cnt++; if (cyc != 209) $display("FAIL noise5_done_cycle got %0d want 209", cyc); else pass_cnt++;
        total_cnt++; if (bus.fail !== 8'h20) $display("FAIL noise5_fail got %h want 20", bus.fail); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'hDF) $display("FAIL noise5_locked got %h want df", bus.locked); else pass_cnt++;
        total_cnt++; if (pulse_delta() != 0) $display("FAIL noise5_pulses got %0d want 0", pulse_delta()); else pass_cnt++;
    endtask

    task automatic test_stuck_lane0();
        int cyc;
        set_modes(3, 0, 0, 0);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        total_cnt++; if (bus.fail !== 8'h00) $display("FAIL stuck0_fail_clear got %h want 00", bus.fail); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'h00) $display("FAIL stuck0_locked_clear got %h want 00", bus.locked); else pass_cnt++;
        while (bus.done !== 1'b1 && cyc < 400) begin
            step();
            cyc++;
        end
        total_cnt++; if (cyc != 211) $display("FAIL stuck0_done_cycle got %0d want 211", cyc); else pass_cnt++;
        total_cnt++; if (pcnt[0] - pbase[0] != 2) $display("FAIL stuck0_pulses got %0d want 2", pcnt[0] - pbase[0]); else pass_cnt++;
        total_cnt++; if (bus.fail !== 8'h01) $display("FAIL stuck0_fail got %h want 01", bus.fail); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'hFE) $display("FAIL stuck0_locked got %h want fe", bus.locked); else pass_cnt++;
    endtask

    task automatic test_abort();
        int cyc;
        int dseen;
        set_modes(0, 0, 0, 0);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        // Lane 2 samples during cycles 47..62.
        while (cyc < 50) begin
            step();
            cyc++;
        end
        dseen = done_seen;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'h03) $display("FAIL abort_locked got %h want 03", bus.locked); else pass_cnt++;
        for (int i = 0; i < 30; i++) step();
        total_cnt++; if (done_seen != dseen) $display("FAIL abort_no_done got %0d want %0d", done_seen, dseen); else pass_cnt++;
        bus.start = 1'b1; bus.abort = 1'b1;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_start_idle got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'h03) $display("FAIL abort_start_status got %h want 03", bus.locked); else pass_cnt++;
        run_to_done(cyc);
        total_cnt++; if (cyc != 169) $display("FAIL restart_done_cycle got %0d want 169", cyc); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'hFF) $display("FAIL restart_locked got %h want ff", bus.locked); else pass_cnt++;
    endtask

    task automatic test_reset_in_slip();
        int cyc;
        set_modes(0, 3, 0, 0);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (bus.bitslip_pulse === 8'h00 && cyc < 200) begin
            step();
            cyc++;
        end
        total_cnt++; if (bus.bitslip_pulse !== 8'h04) $display("FAIL rst_slip_pulse got %h want 04", bus.bitslip_pulse); else pass_cnt++;
        total_cnt++; if (cyc != 63) $display("FAIL rst_slip_cycle got %0d want 63", cyc); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'h03) $display("FAIL rst_pre_locked got %h want 03", bus.locked); else pass_cnt++;
        rst = 1'b1;
        step();
        total_cnt++; if (bus.bitslip_pulse !== 8'h00) $display("FAIL rst_slip_pulse_clr got %h want 00", bus.bitslip_pulse); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_slip_busy got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.locked !== 8'h00) $display("FAIL rst_slip_locked got %h want 00", bus.locked); else pass_cnt++;
        total_cnt++; if (bus.fail !== 8'h00 || bus.done !== 1'b0) $display("FAIL rst_slip_fail_done got %h/%b want 00/0", bus.fail, bus.done); else pass_cnt++;
        rst = 1'b0;
        step(); step();
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_idle_busy got %b want 0", bus.busy); else pass_cnt++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_all_clean();
        test_slip_lane3();
        test_noise_lane5();
        test_stuck_lane0();
        test_abort();
        test_reset_in_slip();
        total_cnt++; if (bad_pulse != 0) $display("FAIL pulse_onehot got %0d want 0", bad_pulse); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
